// File: rtl/cheat_loader.sv
// Cheat-code loader: packs four host words into a 129-bit code and strobes it into the code engine.
// Optional CHEAT_LOADER_WORDSWAP_EN byte-reverses each host word before storage.
module cheat_loader #(
  parameter int MAX_CODES     = 32,
  parameter int STROBE_CYCLES = 2,
  localparam int CW = $clog2(MAX_CODES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_data,
  input  logic          cmd_clear,
  input  logic          cheats_on,
  output logic [128:0]  code,
  output logic          engine_reset,
  output logic          cheats_enable,
  output logic [CW-1:0] code_count,
  output logic          overflow,
  output logic          busy,
  output logic [2:0]    dbg_state
);

  // Handshake: a host word transfers on a rising clk edge where in_valid && in_ready.
  // in_ready is combinational on cmd_clear so a clear request always wins over a word.

  localparam int PW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(STROBE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_CLEAR   = 3'd0,
    S_COLLECT = 3'd1,
    S_SETUP   = 3'd2,
    S_STROBE  = 3'd3,
    S_RELEASE = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [1:0]      word_idx_q, word_idx_d;
  logic [127:0]    fields_q, fields_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            pending_q, pending_d;
  logic            cheats_en_q, cheats_en_d;
  logic [31:0]     word_w;
  logic            phase_last_w;

`ifdef CHEAT_LOADER_WORDSWAP_EN
  assign word_w = {in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]};
`else
  assign word_w = in_data;
`endif

  assign phase_last_w = (phase_q == PHASE_LAST);

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_last_w ? '0 : phase_q + 1'b1;
    word_idx_d  = word_idx_q;
    fields_d    = fields_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    pending_d   = pending_q;
    in_ready    = 1'b0;
    cheats_en_d = cheats_on && (count_q != '0) && (state_q != S_CLEAR);

    case (state_q)
      S_CLEAR: begin
        word_idx_d = '0;
        count_d    = '0;
        overflow_d = 1'b0;
        pending_d  = 1'b0;
        if (phase_last_w) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        phase_d  = '0;
        in_ready = !cmd_clear && !pending_q;
        if (cmd_clear) begin
          state_d = S_CLEAR;
        end else if (in_valid && in_ready) begin
          case (word_idx_q)
            2'd0:    fields_d[127:96] = word_w;
            2'd1:    fields_d[95:64]  = word_w;
            2'd2:    fields_d[63:32]  = word_w;
            default: fields_d[31:0]   = word_w;
          endcase
          word_idx_d = word_idx_q + 2'd1;
          if (word_idx_q == 2'd3) begin
            // A full engine drops the code silently apart from the sticky flag.
            if (count_q < CW'(MAX_CODES)) state_d = S_SETUP;
            else                          overflow_d = 1'b1;
          end
        end
      end
      S_SETUP: begin
        if (cmd_clear) pending_d = 1'b1;
        if (phase_last_w) state_d = S_STROBE;
      end
      S_STROBE: begin
        if (cmd_clear) pending_d = 1'b1;
        if (phase_last_w) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (cmd_clear) pending_d = 1'b1;
        if (phase_last_w) begin
          if (count_q != CW'(MAX_CODES)) count_d = count_q + 1'b1;
          state_d = (pending_q || cmd_clear) ? S_CLEAR : S_COLLECT;
        end
      end
      default: begin
        state_d = S_CLEAR;
        phase_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_CLEAR;
      phase_q     <= '0;
      word_idx_q  <= '0;
      fields_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      pending_q   <= 1'b0;
      cheats_en_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      word_idx_q  <= word_idx_d;
      fields_q    <= fields_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      pending_q   <= pending_d;
      cheats_en_q <= cheats_en_d;
    end
  end

  // Strobe bit decodes straight from state so an asynchronous reset drops it at once.
  assign code          = {state_q == S_STROBE, fields_q};
  assign engine_reset  = (state_q == S_CLEAR);
  assign busy          = (state_q != S_COLLECT);
  assign cheats_enable = cheats_en_q;
  assign code_count    = count_q;
  assign overflow      = overflow_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_cheat_loader.sv
// Bench for cheat_loader: timestamp-based reference model, expected-code queue, per-cycle output checks.
module tb_cheat_loader;
  localparam int MAXC = 32;
  localparam int S    = 2;
  localparam int CW   = $clog2(MAXC + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          cmd_clear;
  logic          cheats_on;
  logic [128:0]  code;
  logic          engine_reset;
  logic          cheats_enable;
  logic [CW-1:0] code_count;
  logic          overflow;
  logic          busy;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  cheat_loader #(.MAX_CODES(MAXC), .STROBE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .cmd_clear(cmd_clear), .cheats_on(cheats_on),
    .code(code), .engine_reset(engine_reset), .cheats_enable(cheats_enable),
    .code_count(code_count), .overflow(overflow), .busy(busy), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [127:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: edges counted from reset release; busy windows kept as end timestamps.
  int          m_e, m_clr_end, m_seq_start, m_cnt, m_idx;
  bit          m_seq, m_pend, m_ovf, m_cen, m_acc, m_prev_strobe;
  logic [31:0] m_f[4];

  function automatic logic [31:0] host_to_field(input logic [31:0] d);
`ifdef CHEAT_LOADER_WORDSWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  function automatic bit m_in_clear();
    return m_e < m_clr_end;
  endfunction

  function automatic bit m_ready(input bit clr);
    return !m_in_clear() && !m_seq && !clr;
  endfunction

  function automatic bit m_strobe();
    return m_seq && (m_e >= m_seq_start + S) && (m_e < m_seq_start + 2 * S);
  endfunction

  task automatic model_reset();
    m_e = 0; m_clr_end = S; m_seq_start = 0; m_cnt = 0; m_idx = 0;
    m_seq = 0; m_pend = 0; m_ovf = 0; m_cen = 0; m_acc = 0; m_prev_strobe = 0;
    for (int i = 0; i < 4; i++) m_f[i] = '0;
    exp_q.delete();
  endtask

  task automatic model_edge(input bit v, input logic [31:0] d, input bit clr, input bit on);
    bit was_clear;
    bit nxt_cen;
    was_clear = m_in_clear();
    nxt_cen   = on && (m_cnt != 0) && !was_clear;
    m_acc     = 0;
    if (was_clear) begin
      m_cnt = 0; m_ovf = 0; m_idx = 0; m_pend = 0;
    end else if (m_seq) begin
      if (clr) m_pend = 1;
      if (m_e + 1 == m_seq_start + 3 * S) begin
        if (m_cnt < MAXC) m_cnt++;
        m_seq = 0;
        if (m_pend) begin
          m_clr_end = m_e + 1 + S;
          m_pend = 0;
        end
      end
    end else if (clr) begin
      m_clr_end = m_e + 1 + S;
    end else if (v) begin
      m_acc = 1;
      m_f[m_idx] = host_to_field(d);
      if (m_idx == 3) begin
        if (m_cnt < MAXC) begin
          m_seq = 1;
          m_seq_start = m_e + 1;
          exp_q.push_back({m_f[0], m_f[1], m_f[2], m_f[3]});
        end else begin
          m_ovf = 1;
        end
      end
      m_idx = (m_idx + 1) % 4;
    end
    m_e++;
    m_cen = nxt_cen;
  endtask

  task automatic check_outputs();
    logic [127:0] exp_code;
    check_eq("in_ready", in_ready, m_ready(cmd_clear));
    check_eq("engine_reset", engine_reset, m_in_clear());
    check_eq("busy", busy, m_in_clear() || m_seq);
    check_eq("strobe_bit", code[128], m_strobe());
    check_eq("code_fields", code[127:0], {m_f[0], m_f[1], m_f[2], m_f[3]});
    check_eq("code_count", code_count, m_cnt);
    check_eq("overflow", overflow, m_ovf);
    check_eq("cheats_enable", cheats_enable, m_cen);
    if (code[128] && !m_prev_strobe) begin
      check_eq("strobe_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp_code = exp_q.pop_front();
        check_eq("strobed_code", code[127:0], exp_code);
      end
    end
    m_prev_strobe = code[128];
  endtask

  task automatic step(input bit v, input logic [31:0] d, input bit clr);
    in_valid = v; in_data = d; cmd_clear = clr;
    #1;
    check_outputs();
    model_edge(v, d, clr, cheats_on);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, $urandom, 0);
  endtask

  task automatic send_word(input logic [31:0] d);
    int guard = 0;
    idle($urandom_range(0, 2));
    do begin
      step(1, d, 0);
      guard++;
    end while (!m_acc && guard < 64);
    check_eq("send_timeout", m_acc, 1);
  endtask

  task automatic send_code(input logic [31:0] w0, w1, w2, w3);
    send_word(w0); send_word(w1); send_word(w2); send_word(w3);
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!m_ready(0) && guard < 64) begin
      step(0, $urandom, 0);
      guard++;
    end
    check_eq("ready_timeout", m_ready(0), 1);
  endtask

  task automatic wait_strobe();
    int guard = 0;
    while (!m_strobe() && guard < 64) begin
      step(0, $urandom, 0);
      guard++;
    end
    check_eq("strobe_timeout", m_strobe(), 1);
  endtask

  initial begin
    reset = 1; in_valid = 0; in_data = '0; cmd_clear = 0; cheats_on = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    model_reset();

    // Reset release: engine_reset for S clocks, then ready.
    check_eq("rst_code", code, 129'd0);
    idle(S);
    check_eq("rst_ready_after_S", in_ready, 1);

    // First directed code.
    cheats_on = 1;
`ifdef CHEAT_LOADER_WORDSWAP_EN
    send_code(32'h01000000, 32'h34120000, 32'h00000000, 32'hEA000000);
`else
    send_code(32'h00000001, 32'h00001234, 32'h00000000, 32'h000000EA);
`endif
    check_eq("dir_fields", code[127:0], {32'h1, 32'h1234, 32'h0, 32'hEA});
    wait_ready();
    check_eq("dir_count", code_count, 1);
    idle(2);

    // Clear with a word presented after two accepted words.
    send_word($urandom); send_word($urandom);
    step(1, 32'hDEADBEEF, 1);
    wait_ready();
    send_code(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    check_eq("fresh_code", code[127:0], {host_to_field(32'hA0), host_to_field(32'hA1),
                                         host_to_field(32'hA2), host_to_field(32'hA3)});
    wait_ready();

    // Clear requested during the strobe phase.
    send_code($urandom, $urandom, $urandom, $urandom);
    wait_strobe();
    step(0, 0, 1);
    wait_ready();
    check_eq("clr_strobe_count", code_count, 0);
    check_eq("clr_strobe_ovf", overflow, 0);

    // Randomized traffic with occasional clears and cheat toggles.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) cheats_on = ~cheats_on;
      step($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 60) == 0);
    end
    wait_ready();

    // Overflow: 33 codes into a 32-deep engine.
    step(0, 0, 1);
    wait_ready();
    for (int k = 0; k < MAXC + 1; k++) begin
      send_code($urandom, $urandom, $urandom, $urandom);
      wait_ready();
    end
    idle(3);
    check_eq("ovf_count", code_count, MAXC);
    check_eq("ovf_flag", overflow, 1);
    check_eq("exp_q_drained", exp_q.size(), 0);

    // Reset asserted mid-strobe.
    step(0, 0, 1);
    wait_ready();
    send_code($urandom, $urandom, $urandom, $urandom);
    wait_strobe();
    reset = 1;
    #1;
    check_eq("rst_mid_strobe", code[128], 0);
    check_eq("rst_mid_engine_reset", engine_reset, 1);
    check_eq("rst_mid_count", code_count, 0);
    @(negedge clk);
    reset = 0;
    model_reset();
    idle(S + 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cheat_loader.md
# cheat_loader

Sequencer that feeds the cheat-code engine. It takes a stream of 32-bit words from the host bridge and assembles each group of four words into one 129-bit code word. It then drives the engine's clock-bit strobe with defined setup, strobe and release phases. It also issues engine clears, tracks how many codes have been loaded, and gates the engine's enable. It sits between the host bridge and the code-engine instance.

## Interface
- MAX_CODES, 32, capacity of the downstream code engine; loads beyond this are dropped
- STROBE_CYCLES, 2, length in clocks of each of the setup, strobe, release and clear phases; must be ≥1
- clk  in  1  system clock; the engine runs on the same clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  host word valid
- in_ready  out  1  block accepts a word this cycle
- in_data  in  32  host word; big-endian fields
- cmd_clear  in  1  request to clear all codes (level, sampled each clock)
- cheats_on  in  1  user cheat toggle
- code  out  129  to engine: bit 128 is the clock/strobe; bits 127:96 flags, 95:64 address, 63:32 compare, 31:0 replace
- engine_reset  out  1  to engine reset
- cheats_enable  out  1  to engine enable
- code_count  out  $clog2(MAX_CODES+1)  codes strobed since the last clear
- overflow  out  1  sticky: a code was dropped because code_count == MAX_CODES
- busy  out  1  high in every state except COLLECT

## Operation
- States: CLEAR, COLLECT, SETUP, STROBE, RELEASE.
- CLEAR
  - engine_reset=1 for STROBE_CYCLES clocks.
  - word_idx, code_count and overflow are zeroed.
  - Then COLLECT.
- COLLECT
  - in_ready = !cmd_clear && !clear_pending.
  - Each accepted word is written to the code field selected by word_idx (0: flags, 1: address, 2: compare, 3: replace).
  - word_idx then increments, wrapping 3→0.
  - On the accept with word_idx==3:
    - if code_count < MAX_CODES, go to SETUP;
    - otherwise set overflow, drop the code, no strobe, stay in COLLECT.
- SETUP: code[127:0] stable, code[128]=0, for STROBE_CYCLES clocks.
- STROBE: code[128]=1 for STROBE_CYCLES clocks.
- RELEASE
  - code[128]=0 for STROBE_CYCLES clocks.
  - On exit, code_count increments.
  - Then go to CLEAR if clear_pending is set, else COLLECT.
- Duplicate addresses re-enable an existing engine slot, but they still increment code_count. The count is therefore an upper bound, and overflow is conservative.
- cmd_clear
  - In COLLECT: go to CLEAR next clock. A word presented in that same cycle is not accepted.
  - In SETUP, STROBE or RELEASE: sets clear_pending. The running strobe sequence completes first, then CLEAR runs. clear_pending is zeroed on CLEAR entry.
- Partially collected words are discarded by CLEAR. code[127:0] holds its last value; it is not zeroed by CLEAR.
- cheats_enable is registered: cheats_on && code_count!=0 && state!=CLEAR.

## Timing
- Reset values:
  - state=CLEAR, so engine_reset=1, busy=1, in_ready=0
  - code=0, code_count=0, overflow=0, cheats_enable=0
  - word_idx=0, clear_pending=0
- After reset deasserts, engine_reset stays high for STROBE_CYCLES clocks, then in_ready rises.
- Fourth word accepted at edge N (S=STROBE_CYCLES):
  - code[127:0] updates at N.
  - code[128] rises at N+S and falls at N+2S.
  - in_ready reasserts at N+3S.
  - Minimum code pitch is 4 accepts + 3S clocks.
- The engine edge-detects code[128], so any S≥1 is correct. S=2 gives margin.
- Reset asserted mid-strobe: code[128] drops to 0 immediately, the asynchronous reset forces CLEAR, and the engine is cleared by engine_reset.
- code_count saturates at MAX_CODES and never wraps.

## Configuration
- CHEAT_LOADER_WORDSWAP_EN
  - Defined: each in_data word is byte-reversed before storage (little-endian host → big-endian fields).
  - Undefined: words are stored unchanged, and the host must pre-swap.

## Test plan
- Reset release, S=2 → engine_reset high for 2 clocks after deassert; in_ready=1 on the 3rd; all other outputs 0.
- Words 0x00000001, 0x00001234, 0x00000000, 0x000000EA → code[127:0]={0x1,0x1234,0x0,0xEA}; code[128] high exactly 2 clocks, starting 2 clocks after the 4th accept; code_count=1; in_ready back 6 clocks after the 4th accept.
- Load 33 codes with MAX_CODES=32 → 32 strobes; 33rd produces no code[128] pulse; overflow=1; code_count=32.
- cmd_clear pulsed during STROBE → code[128] pulse completes full length; engine_reset pulse follows RELEASE; code_count=0; overflow=0.
- cmd_clear with in_valid high after 2 words accepted → word not accepted; CLEAR runs; next 4 words form a fresh code starting at flags.
- With CHEAT_LOADER_WORDSWAP_EN, in_data=0x34120000 as word 1 → code[95:64]=0x00001234.
